// File: rtl/seq_mult_ctrl.sv
// Radix-2 shift-add unsigned multiplier controller. It drives an external
// 16-bit adder (adder_16) for one iteration per multiplier bit.
module seq_mult_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [15:0]      add_sum,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             busy,
    output logic             done,
    output logic [15:0]      product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [15:0]      acc_reg, acc_next;
    logic [15:0]      mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplr_reg, mplr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      product_reg, product_next;
    logic             done_reg, done_next;
    logic             calc_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplr_reg    <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            mplr_reg    <= mplr_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        mplr_next    = mplr_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next = {{(16 - WIDTH){1'b0}}, in_a};
                    mplr_next  = in_b;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                acc_next   = add_sum;
                mcand_next = mcand_reg << 1;
                mplr_next  = mplr_reg >> 1;
                cnt_next   = cnt_reg + CNT_W'(1);
                // Fixed iteration count: no early exit even when mplr is already zero.
                if (cnt_reg == LAST_CNT) begin
                    product_next = add_sum;
                    done_next    = 1'b1;
                    state_next   = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Adder operands depend only on registers, so start has no path to the adder.
    assign calc_active = (state_reg == CALC);
    assign add_a       = calc_active ? acc_reg : 16'd0;

    for (genvar gi = 0; gi < 16; gi++) begin : g_add_b
        assign add_b[gi] = calc_active & mplr_reg[0] & mcand_reg[gi];
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign product = product_reg;

endmodule
